// File: rtl/axi4l_pkg.sv
// axi4l_pkg: response codes and register address decode shared by the register file.
package axi4l_pkg;
  typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;
  // Returns {valid, idx}; an address below base is rejected rather than wrapped.
  function automatic logic [8:0] decode_addr(input logic [63:0] addr, input logic [63:0] base,
                                             input logic [63:0] num_regs, input logic [63:0] bytes);
    logic [63:0] off;
    off = addr - base;
    return {addr >= base && off % bytes == 64'd0 && off / bytes < num_regs, 8'(off / bytes)};
  endfunction
endpackage

// File: rtl/axi4l_sync_fifo.sv
// axi4l_sync_fifo: single-clock FIFO; full/empty derive only from the registered count.
module axi4l_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_data,
  input  logic                    i_pop,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = DEPTH[PW:0];
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0] r_count;
  logic w_push, w_pop;
  assign o_full  = r_count == FULL;
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data  = r_mem[r_rp];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  always_ff @(posedge CLK)
    if (w_push) r_mem[r_wp] <= i_data;
  always_ff @(posedge CLK)
    if (RESET) begin
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
    end
endmodule

// File: rtl/axi4l_param_regfile.sv
// axi4l_param_regfile: AXI4-Lite register file of RW control and RO status registers.
// Define AXI4L_REGFILE_WR_PULSE_EN to add the per-register wr_pulse commit strobes.
module axi4l_param_regfile
  import axi4l_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    NUM_REGS      = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    WR_FIFO_DEPTH = 4,
  parameter logic [NUM_REGS-1:0]   RO_MASK       = '0
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [ADDR_WIDTH-1:0]          S_AWADDR,
  input  logic                           S_AWVALID,
  output logic                           S_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_WSTRB,
  input  logic                           S_WVALID,
  output logic                           S_WREADY,
  output logic [1:0]                     S_BRESP,
  output logic                           S_BVALID,
  input  logic                           S_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_ARADDR,
  input  logic                           S_ARVALID,
  output logic                           S_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_RDATA,
  output logic [1:0]                     S_RRESP,
  output logic                           S_RVALID,
  input  logic                           S_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status
`ifdef AXI4L_REGFILE_WR_PULSE_EN
  , output logic [NUM_REGS-1:0]          wr_pulse
`endif
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW = $clog2(WR_FIFO_DEPTH) + 1;
  localparam logic [255:0] RO_ALL = 256'(RO_MASK);
  logic [ADDR_WIDTH-1:0] w_aw_addr;
  logic [DATA_WIDTH+BYTES-1:0] w_w_entry;
  logic [DATA_WIDTH-1:0] w_w_data, w_rdata;
  logic [BYTES-1:0] w_w_strb;
  logic w_aw_full, w_aw_empty, w_w_full, w_w_empty;
  logic [CW-1:0] w_aw_count, w_w_count;
  logic w_commit, w_wr_ok, w_ar_hs;
  logic [8:0] w_wdec, w_rdec;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic r_bvalid, r_rvalid;
  resp_t r_bresp, r_rresp;

  axi4l_sync_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(WR_FIFO_DEPTH)) u_aw_fifo (
    .CLK, .RESET, .i_push(S_AWVALID), .i_data(S_AWADDR), .i_pop(w_commit),
    .o_data(w_aw_addr), .o_full(w_aw_full), .o_empty(w_aw_empty), .o_count(w_aw_count));
  axi4l_sync_fifo #(.WIDTH(DATA_WIDTH + BYTES), .DEPTH(WR_FIFO_DEPTH)) u_w_fifo (
    .CLK, .RESET, .i_push(S_WVALID), .i_data({S_WDATA, S_WSTRB}), .i_pop(w_commit),
    .o_data(w_w_entry), .o_full(w_w_full), .o_empty(w_w_empty), .o_count(w_w_count));

  assign {w_w_data, w_w_strb} = w_w_entry;
  assign S_AWREADY = !w_aw_full;
  assign S_WREADY  = !w_w_full;
  assign w_commit  = !w_aw_empty && !w_w_empty && (!r_bvalid || S_BREADY);
  assign w_wdec    = decode_addr(64'(w_aw_addr), 64'(BASE_ADDR), 64'(NUM_REGS), 64'(BYTES));
  assign w_wr_ok   = w_wdec[8] && !RO_ALL[w_wdec[7:0]];
  assign S_BVALID  = r_bvalid;
  assign S_BRESP   = r_bresp;
  assign S_ARREADY = !r_rvalid || S_RREADY;
  assign w_ar_hs   = S_ARVALID && S_ARREADY;
  assign w_rdec    = decode_addr(64'(S_ARADDR), 64'(BASE_ADDR), 64'(NUM_REGS), 64'(BYTES));
  assign S_RVALID  = r_rvalid;
  assign S_RRESP   = r_rresp;
  assign S_RDATA   = r_rdata;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : r_regs[i];
  end

  always_ff @(posedge CLK)
    for (int i = 0; i < NUM_REGS; i++)
      if (RESET) r_regs[i] <= '0;
      else if (w_commit && w_wr_ok && w_wdec[7:0] == 8'(i))
        for (int b = 0; b < BYTES; b++)
          if (w_w_strb[b]) r_regs[i][8*b +: 8] <= w_w_data[8*b +: 8];

  // A commit in the handshake cycle keeps BVALID up for back-to-back responses.
  always_ff @(posedge CLK)
    if (RESET) begin
      r_bvalid <= 1'b0;
      r_bresp <= OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp <= w_wr_ok ? OKAY : SLVERR;
    end else if (S_BREADY) r_bvalid <= 1'b0;

  // Reads sample the registers before any same-edge commit lands.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_rdec[8] && w_rdec[7:0] == 8'(i))
        w_rdata = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
  end

  always_ff @(posedge CLK)
    if (RESET) begin
      r_rvalid <= 1'b0;
      r_rresp <= OKAY;
      r_rdata <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp <= w_rdec[8] ? OKAY : SLVERR;
      r_rdata <= w_rdata;
    end else if (S_RREADY) r_rvalid <= 1'b0;

`ifdef AXI4L_REGFILE_WR_PULSE_EN
  always_ff @(posedge CLK)
    for (int i = 0; i < NUM_REGS; i++)
      wr_pulse[i] <= !RESET && w_commit && w_wr_ok && w_wdec[7:0] == 8'(i);
`endif
endmodule
